// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Scans one digit per SCAN_DIV clocks, inserts a blank guard cycle at each digit change,
// and double-buffers the displayed BCD value so a frame never mixes two loads.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      asynchronous active-high reset
//   bcd_in     four BCD digits, [15:12]=digit3 ... [3:0]=digit0
//   load       capture bcd_in for display (committed at the next frame boundary)
//   blank_lz   blank digit3 when it is zero (sampled live)
//   dp_mask    per-digit decimal point request (sampled live)
//   an         active-low digit enables, bit n = digit n (registered)
//   seg        active-low segments, bit0=a ... bit6=g (registered)
//   dp         active-low decimal point (registered)
//   frame_done one-clock pulse after each completed 4-digit frame (registered)
module seg7_scan_driver #(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned SCAN_HZ    = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] bcd_in,
   input  logic        load,
   input  logic        blank_lz,
   input  logic [3:0]  dp_mask,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int unsigned SCAN_DIV = CLOCK_FREQ / SCAN_HZ;
   localparam int unsigned CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_OFF = 7'h7F;

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_idx;
   logic [15:0]      r_disp;
   logic [15:0]      r_pend;
   logic             r_pend_valid;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp;
   logic             r_frame_done;

   logic             w_dwell_wrap;
   logic             w_frame_wrap;
   logic [3:0]       w_digit;
   logic [6:0]       w_seg_dec;
   logic [3:0]       w_an_nxt;
   logic [6:0]       w_seg_nxt;
   logic             w_dp_nxt;

   // Active-low gfedcba decode; non-BCD nibbles are dark.
   function automatic logic [6:0] decode_bcd(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

   // Next-output computation from the current (pre-edge) state.
   always_comb begin
      w_dwell_wrap = (r_cnt == CNT_MAX);
      w_frame_wrap = w_dwell_wrap && (r_idx == 2'd3);

      case (r_idx)
         2'd0:    w_digit = r_disp[3:0];
         2'd1:    w_digit = r_disp[7:4];
         2'd2:    w_digit = r_disp[11:8];
         default: w_digit = r_disp[15:12];
      endcase

      w_seg_dec = decode_bcd(w_digit);

      w_an_nxt  = 4'hF;
      w_seg_nxt = SEG_OFF;
      w_dp_nxt  = 1'b1;
      // Dwell count 0 is the guard cycle: everything dark while the digit changes.
      if (r_cnt != '0) begin
         w_an_nxt = ~(4'b0001 << r_idx);
         w_dp_nxt = ~dp_mask[r_idx];
         if ((r_idx == 2'd3) && blank_lz && (w_digit == 4'd0)) begin
            w_seg_nxt = SEG_OFF;
         end else begin
            w_seg_nxt = w_seg_dec;
         end
      end
   end

   // Scan counters, double buffer and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_idx        <= 2'd0;
         r_disp       <= 16'h0000;
         r_pend       <= 16'h0000;
         r_pend_valid <= 1'b0;
         r_an         <= 4'hF;
         r_seg        <= SEG_OFF;
         r_dp         <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         if (w_dwell_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         // A load landing exactly on the frame boundary bypasses the pending slot.
         if (load && w_frame_wrap) begin
            r_disp       <= bcd_in;
            r_pend_valid <= 1'b0;
         end else begin
            if (w_frame_wrap && r_pend_valid) begin
               r_disp       <= r_pend;
               r_pend_valid <= 1'b0;
            end
            if (load) begin
               r_pend       <= bcd_in;
               r_pend_valid <= 1'b1;
            end
         end

         r_an         <= w_an_nxt;
         r_seg        <= w_seg_nxt;
         r_dp         <= w_dp_nxt;
         r_frame_done <= w_frame_wrap;
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_done = r_frame_done;

endmodule
